// File: rtl/beep_sound_arbiter.sv
// Fixed-priority arbiter sharing one piezo between background music (source 0) and three sound effects.
// Optional build macro BEEP_ARB_PREEMPT_EN lets a higher-index effect cut off the one playing.
module beep_sound_arbiter #(
    parameter int TICK_CYCLES  = 12500000,
    parameter int EFFECT_TICKS = 4,
    parameter int GAP_CYCLES   = 1250000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_gamemode,
    input  logic [3:0] i_req,
    input  logic [3:0] i_src_beep,
    output logic [3:0] o_src_en,
    output logic [1:0] o_active_id,
    output logic       o_busy,
    output logic       o_beep
);

    localparam int CNT_MAX = (TICK_CYCLES > GAP_CYCLES) ? TICK_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DUR_W   = (EFFECT_TICKS > 1) ? $clog2(EFFECT_TICKS) : 1;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [DUR_W-1:0] DUR_LOAD  = DUR_W'(EFFECT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BG,
        ST_EFFECT,
        ST_GAP
    } state_t;

    state_t           r_state;
    logic [3:1]       r_pending;
    logic [CNT_W-1:0] r_tick;
    logic [DUR_W-1:0] r_dur;
    logic [3:0]       r_src_en;
    logic [1:0]       r_active_id;
    logic             r_busy;
    logic             r_beep;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_tick_nxt;
    logic [DUR_W-1:0] w_dur_nxt;
    logic [1:0]       w_id_nxt;
    logic [3:1]       w_clear;
    logic [3:1]       w_pending_nxt;
    logic [3:0]       w_src_en_nxt;
    logic [1:0]       w_active_id_nxt;
    logic             w_busy_nxt;
    logic             w_pause;
    logic             w_grant_vld;
    logic [1:0]       w_grant_id;
    logic             w_load;
    logic             w_preempt;
    logic             w_unused;

    // Source 0 is never requested; its request bit is deliberately ignored.
    assign w_unused    = i_req[0];
    assign w_pause     = (i_gamemode == 2'b11);
    assign w_grant_vld = |r_pending;
    assign w_grant_id  = r_pending[3] ? 2'd3 : (r_pending[2] ? 2'd2 : 2'd1);

`ifdef BEEP_ARB_PREEMPT_EN
    assign w_preempt = w_grant_vld && (w_grant_id > r_active_id);
`else
    assign w_preempt = 1'b0;
`endif

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_dur_nxt   = r_dur;
        w_id_nxt    = r_active_id;
        w_load      = 1'b0;
        w_clear     = '0;

        if (w_pause) begin
            w_state_nxt = ST_IDLE;
            w_tick_nxt  = '0;
            w_dur_nxt   = '0;
            w_id_nxt    = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) w_load = 1'b1;
                    else if (i_gamemode == 2'b00) w_state_nxt = ST_BG;
                end
                ST_BG: begin
                    if (w_grant_vld) w_load = 1'b1;
                    else if (i_gamemode != 2'b00) w_state_nxt = ST_IDLE;
                end
                ST_EFFECT: begin
                    if (w_preempt) begin
                        w_load = 1'b1;
                    end else if (r_tick == TICK_LAST) begin
                        w_tick_nxt = '0;
                        if (r_dur == '0) w_state_nxt = ST_GAP;
                        else w_dur_nxt = r_dur - 1'b1;
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_tick == GAP_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_tick_nxt  = '0;
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase

            if (w_load) begin
                w_state_nxt = ST_EFFECT;
                w_id_nxt    = w_grant_id;
                w_tick_nxt  = '0;
                w_dur_nxt   = DUR_LOAD;
                w_clear     = {w_grant_id == 2'd3, w_grant_id == 2'd2, w_grant_id == 2'd1};
            end
        end
    end

    // A new request on the same edge as its grant-clear survives, so the effect replays after the gap.
    assign w_pending_nxt = w_pause ? '0 : ((r_pending & ~w_clear) | i_req[3:1]);

    always_comb begin
        w_src_en_nxt    = 4'b0000;
        w_active_id_nxt = 2'd0;
        w_busy_nxt      = 1'b0;
        case (w_state_nxt)
            ST_BG:     w_src_en_nxt = 4'b0001;
            ST_EFFECT: begin
                w_src_en_nxt    = 4'b0001 << w_id_nxt;
                w_active_id_nxt = w_id_nxt;
                w_busy_nxt      = 1'b1;
            end
            ST_GAP:    w_busy_nxt = 1'b1;
            default:   w_busy_nxt = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_tick      <= '0;
            r_dur       <= '0;
            r_src_en    <= 4'b0000;
            r_active_id <= 2'd0;
            r_busy      <= 1'b0;
            r_beep      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_tick      <= w_tick_nxt;
            r_dur       <= w_dur_nxt;
            r_src_en    <= w_src_en_nxt;
            r_active_id <= w_active_id_nxt;
            r_busy      <= w_busy_nxt;
            r_beep      <= ((r_state == ST_BG) || (r_state == ST_EFFECT)) ?
                           i_src_beep[r_active_id] : 1'b0;
        end
    end

    assign o_src_en    = r_src_en;
    assign o_active_id = r_active_id;
    assign o_busy      = r_busy;
    assign o_beep      = r_beep;

endmodule

// File: tb/tb_beep_sound_arbiter.sv
// Directed bench for beep_sound_arbiter with TICK_CYCLES=10, EFFECT_TICKS=2, GAP_CYCLES=3 (effect = 20 cycles).
module tb_beep_sound_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gamemode;
    logic [3:0] req;
    logic [3:0] src_beep;
    logic [3:0] src_en;
    logic [1:0] active_id;
    logic       busy;
    logic       beep;

    int checks = 0;
    int errors = 0;

    beep_sound_arbiter #(
        .TICK_CYCLES (10),
        .EFFECT_TICKS(2),
        .GAP_CYCLES  (3)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_gamemode (gamemode),
        .i_req      (req),
        .i_src_beep (src_beep),
        .o_src_en   (src_en),
        .o_active_id(active_id),
        .o_busy     (busy),
        .o_beep     (beep)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares {src_en, active_id, busy} as one packed value.
    task automatic chk_st(input string tag, input logic [3:0] en, input logic [1:0] id, input logic b);
        chk(tag, {1'b0, src_en, active_id, busy}, {1'b0, en, id, b});
    endtask

    initial begin
        rst = 1'b1; gamemode = 2'b00; req = 4'b0000; src_beep = 4'b0000;
        step(1);
        chk_st("reset_state", 4'b0000, 2'd0, 1'b0);
        chk("reset_beep", {7'b0, beep}, 8'd0);

        // Start page: one IDLE cycle, then background music with a one-cycle beep lag.
        rst = 1'b0; src_beep = 4'b0001;
        step(1);
        chk_st("bg_enter", 4'b0001, 2'd0, 1'b0);
        chk("bg_beep_first", {7'b0, beep}, 8'd0);
        step(1);
        chk("bg_beep_follow", {7'b0, beep}, 8'd1);
        src_beep = 4'b0000;
        step(1);
        chk("bg_beep_low", {7'b0, beep}, 8'd0);

        // Effect 2 requested from BG: latch, then 20 cycles, 3 gap cycles, IDLE, BG.
        src_beep = 4'b0100; req = 4'b0100;
        step(1); req = 4'b0000;
        chk_st("req2_latched", 4'b0001, 2'd0, 1'b0);
        step(1);
        chk_st("eff2_start", 4'b0100, 2'd2, 1'b1);
        chk("eff2_beep_lag", {7'b0, beep}, 8'd0);
        step(1);
        chk("eff2_beep", {7'b0, beep}, 8'd1);
        step(18);
        chk_st("eff2_last", 4'b0100, 2'd2, 1'b1);
        step(1);
        chk_st("gap_first", 4'b0000, 2'd0, 1'b1);
        step(1);
        chk("gap_beep", {7'b0, beep}, 8'd0);
        step(1);
        chk_st("gap_last", 4'b0000, 2'd0, 1'b1);
        step(1);
        chk_st("idle_after_gap", 4'b0000, 2'd0, 1'b0);
        step(1);
        chk_st("bg_resume", 4'b0001, 2'd0, 1'b0);

        // Playing: req1 and req3 together, 3 wins, 1 follows after the gap.
        gamemode = 2'b01; req = 4'b1010;
        step(1); req = 4'b0000;
        chk_st("play_idle", 4'b0000, 2'd0, 1'b0);
        step(1);
        chk_st("eff3_first", 4'b1000, 2'd3, 1'b1);
        step(19);
        chk_st("eff3_last", 4'b1000, 2'd3, 1'b1);
        step(1);
        chk_st("eff3_gap", 4'b0000, 2'd0, 1'b1);
        step(3);
        chk_st("eff3_idle", 4'b0000, 2'd0, 1'b0);
        step(1);
        chk_st("eff1_first", 4'b0010, 2'd1, 1'b1);
        step(5);
        req = 4'b1000;
        step(1); req = 4'b0000;
        chk_st("eff1_req3_latch", 4'b0010, 2'd1, 1'b1);
`ifdef BEEP_ARB_PREEMPT_EN
        step(1);
        chk_st("preempt_to3", 4'b1000, 2'd3, 1'b1);
        step(19);
        chk_st("preempt_eff3_last", 4'b1000, 2'd3, 1'b1);
        step(1);
        chk_st("preempt_gap", 4'b0000, 2'd0, 1'b1);
        step(3);
        chk_st("preempt_idle", 4'b0000, 2'd0, 1'b0);
        step(1);
        chk_st("preempt_dropped", 4'b0000, 2'd0, 1'b0);
`else
        step(13);
        chk_st("eff1_last", 4'b0010, 2'd1, 1'b1);
        step(1);
        chk_st("eff1_gap", 4'b0000, 2'd0, 1'b1);
        step(3);
        chk_st("eff1_idle", 4'b0000, 2'd0, 1'b0);
        step(1);
        chk_st("eff3_waited", 4'b1000, 2'd3, 1'b1);
        step(19);
        chk_st("eff3_waited_last", 4'b1000, 2'd3, 1'b1);
        step(1);
        chk_st("eff3_waited_gap", 4'b0000, 2'd0, 1'b1);
        step(3);
        chk_st("eff3_waited_idle", 4'b0000, 2'd0, 1'b0);
        step(1);
        chk_st("idle_stays", 4'b0000, 2'd0, 1'b0);
`endif

        // Pause mid-effect: immediate silence, beep one cycle later, paused requests lost.
        req = 4'b0100;
        step(1); req = 4'b0000;
        step(1);
        chk_st("pause_eff2", 4'b0100, 2'd2, 1'b1);
        step(3);
        gamemode = 2'b11;
        step(1);
        chk_st("pause_state", 4'b0000, 2'd0, 1'b0);
        chk("pause_beep_lag", {7'b0, beep}, 8'd1);
        step(1);
        chk("pause_beep_off", {7'b0, beep}, 8'd0);
        req = 4'b0100;
        step(1); req = 4'b0000;
        step(1);
        gamemode = 2'b01;
        step(1);
        chk_st("unpause_idle", 4'b0000, 2'd0, 1'b0);
        step(2);
        chk_st("paused_req_lost", 4'b0000, 2'd0, 1'b0);

        // Reset mid-effect with a lower request still pending.
        req = 4'b0100;
        step(1); req = 4'b0000;
        step(1);
        chk_st("rst_eff2", 4'b0100, 2'd2, 1'b1);
        req = 4'b0010;
        step(1); req = 4'b0000;
        step(1);
        rst = 1'b1; gamemode = 2'b00;
        step(1);
        chk_st("rst_mid_effect", 4'b0000, 2'd0, 1'b0);
        chk("rst_mid_beep", {7'b0, beep}, 8'd0);
        rst = 1'b0;
        step(1);
        chk_st("bg_after_rst", 4'b0001, 2'd0, 1'b0);

        // Request held across its own grant edge: set wins, effect replays after the gap.
        req = 4'b1000;
        step(1);
        chk_st("retrig_latch", 4'b0001, 2'd0, 1'b0);
        step(1); req = 4'b0000;
        chk_st("retrig_start", 4'b1000, 2'd3, 1'b1);
        step(20);
        chk_st("retrig_gap", 4'b0000, 2'd0, 1'b1);
        step(3);
        chk_st("retrig_idle", 4'b0000, 2'd0, 1'b0);
        step(1);
        chk_st("retrig_replay", 4'b1000, 2'd3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beep_sound_arbiter.md
Name: beep_sound_arbiter

Overview:
- Shares the single piezo `beep` output between one background-music generator (source 0) and up to three one-shot sound-effect generators (sources 1..3).
- Arbitrates by fixed priority, times each effect in 125 ms units, inserts a silent gap between sounds, and mutes everything on pause.
- Sits between the `gamemode` FSM and the per-sound tone generators.
- Drives each generator's enable and muxes its PWM bit to the top-level buzzer pin.

Parameters:
- TICK_CYCLES, 12500000, clk cycles per 125 ms time unit.
- EFFECT_TICKS, 4, length of one effect in time units (>=1).
- GAP_CYCLES, 1250000, silent cycles after each effect (>=1).

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  synchronous reset, active-high.
- gamemode  input  2  00 start page, 01 playing, 10 game over, 11 paused.
- req  input  4  one-cycle effect request pulses; bit0 ignored.
- src_beep  input  4  PWM bit from each tone generator.
- src_en  output  4  one-hot enable to the granted generator; 0 when silent.
- active_id  output  2  index of the granted source; 0 when silent.
- busy  output  1  high in states EFFECT and GAP.
- beep  output  1  registered buzzer drive.

Behaviour:
- Reset, applied synchronously on `rst`=1 at a clk edge:
  - state IDLE, pending=0, tick and duration counters 0.
  - src_en=0, active_id=0, busy=0, beep=0.
- Pending latches:
  - `req[k]` (k=1..3) sets pending[k] at the clock edge.
  - If a set and a grant-clear of the same bit occur in the same cycle, the set wins and the bit stays pending, so the effect retriggers after the gap.
  - A request for the currently playing id also sets pending and replays after the gap.
- Grant selection: highest pending index wins, 3 > 2 > 1.
- States and transitions:
  - IDLE: silent.
    - If any pending and gamemode!=11: go to EFFECT(id), clear pending[id], tick=0, dur=EFFECT_TICKS-1.
    - Else if gamemode==00: go to BG.
  - BG: src_en=0001.
    - Pending effect: go directly to EFFECT, with the same load as from IDLE.
    - gamemode!=00: go to IDLE.
  - EFFECT: src_en=one-hot(id), active_id=id, busy=1.
    - tick counts 0..TICK_CYCLES-1 and wraps.
    - On wrap, if dur==0 go to GAP; else dur decrements.
    - Total length is exactly EFFECT_TICKS*TICK_CYCLES cycles.
  - GAP: src_en=0, busy=1, counts GAP_CYCLES cycles, then goes to IDLE.
- Pause: gamemode==11 in any state forces IDLE on the next edge.
  - pending is cleared, and req is ignored while paused.
  - Pause has priority over all other transitions.
- Output timing:
  - src_en, active_id and busy are registered state decodes; they change on the edge that changes state.
  - beep <= src_beep[active_id] when the state is BG or EFFECT, else 0. beep therefore lags src_en by one cycle.
- Counter widths: wide enough for TICK_CYCLES-1, EFFECT_TICKS-1 and GAP_CYCLES-1. No overflow is possible.
- Source 0 is never pending; the background generator restarts its melody via its own reset whenever src_en[0] falls.

Optional Feature:
- Macro `BEEP_ARB_PREEMPT_EN`.
- Defined:
  - In EFFECT, a pending index greater than the current id switches to EFFECT(new id) on the next edge.
  - The new id's pending bit is cleared, tick and dur are reloaded, and no gap is inserted.
  - The preempted effect is dropped, not resumed.
- Undefined: effects always run to completion; higher requests wait in pending.

Test Plan (TICK_CYCLES=10, EFFECT_TICKS=2, GAP_CYCLES=3):
- Reset, gamemode=00 → one cycle IDLE then BG: src_en=0001, busy=0; beep follows src_beep[0] with 1-cycle lag.
- In BG, pulse req[2] → next edge src_en=0100, active_id=2, busy=1 for exactly 20 cycles; then 3 cycles src_en=0 with busy=1; then IDLE 1 cycle; then BG.
- gamemode=01, req[1] and req[3] pulsed in the same cycle → effect 3 runs (20 cycles), gap of 3 cycles, IDLE, then effect 1 (20 cycles), then IDLE stays silent.
- During effect 1 at cycle 5, pulse req[3]:
  - Without the macro: 3 plays after effect 1 and its gap.
  - With `BEEP_ARB_PREEMPT_EN`: src_en=1000 on the next edge, running a full 20 cycles.
- Mid-effect, set gamemode=11 → next edge src_en=0, busy=0, beep=0 one cycle later; req[2] pulsed while paused is lost after returning to 01.
- Assert rst mid-EFFECT for 1 cycle → next edge all outputs 0 and pending cleared; with gamemode=00, BG resumes after one IDLE cycle.
